// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multi-cycle MIPS control path.
//   statetype_t    : main FSM state encodings, FETCH = 0
//   OP_*           : opcode field values (instr[31:26])
//   ALUOP_*        : aluop values consumed by the ALU decoder
//   ALUSRCB_*      : ALU B operand select values
//   PCSRC_*        : PC source select values
//   op_supported() : 1 when the opcode has a defined instruction sequence
// Configuration macro: MAINFSM_JUMP_EN (when defined, OP_J is a supported opcode).
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Jump support is a build option, so whether OP_J counts as legal follows it.
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: op_supported = 1'b1;
`ifdef MAINFSM_JUMP_EN
      OP_J:                                    op_supported = 1'b1;
`endif
      default:                                 op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mainfsm_if.sv
// mainfsm_if: control bundle between the main FSM and the datapath.
//   op          : opcode from the instruction register (datapath -> FSM)
//   irwrite, pcwrite, branch, memwrite, regwrite : write enables
//   iord, memtoreg, regdst, alusrca              : mux selects
//   alusrcb, pcsrc, aluop                        : 2-bit selects
//   illegal_op  : one-cycle pulse after an unsupported opcode
//   state       : current FSM state, for debug
// Modports: master = FSM side, slave = datapath side.
interface mainfsm_if;
  logic [5:0] op;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op,
    output irwrite, pcwrite, branch, memwrite, regwrite,
    output iord, memtoreg, regdst, alusrca,
    output alusrcb, pcsrc, aluop, illegal_op, state
  );

  modport slave (
    output op,
    input  irwrite, pcwrite, branch, memwrite, regwrite,
    input  iord, memtoreg, regdst, alusrca,
    input  alusrcb, pcsrc, aluop, illegal_op, state
  );
endinterface

// File: rtl/mainfsm_outdec.sv
// mainfsm_outdec: Moore output decode, state -> datapath control word.
//   state_i   : current FSM state
//   *_o       : write enables, mux selects, alusrcb/pcsrc/aluop
// Every signal not named for a state is 0 in that state.
// Configuration macro: MAINFSM_JUMP_EN (JEX decode is only built when defined,
// so pcsrc can only be PCSRC_JUMP in jump-enabled builds).
module mainfsm_outdec
  import mips_pkg::*;
(
  input  statetype_t state_i,
  output logic       irwrite_o,
  output logic       pcwrite_o,
  output logic       branch_o,
  output logic       memwrite_o,
  output logic       regwrite_o,
  output logic       iord_o,
  output logic       memtoreg_o,
  output logic       regdst_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsrc_o,
  output logic [1:0] aluop_o
);

  always_comb begin
    irwrite_o  = 1'b0;
    pcwrite_o  = 1'b0;
    branch_o   = 1'b0;
    memwrite_o = 1'b0;
    regwrite_o = 1'b0;
    iord_o     = 1'b0;
    memtoreg_o = 1'b0;
    regdst_o   = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = ALUSRCB_REG;
    pcsrc_o    = PCSRC_ALU;
    aluop_o    = ALUOP_ADD;
    case (state_i)
      FETCH: begin
        irwrite_o = 1'b1;
        pcwrite_o = 1'b1;
        alusrcb_o = ALUSRCB_FOUR;
      end
      // Precompute the branch target while the opcode is being decoded.
      DECODE:  alusrcb_o = ALUSRCB_IMMSH;
      MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = ALUSRCB_IMM;
      end
      MEMRD:   iord_o = 1'b1;
      MEMWB: begin
        memtoreg_o = 1'b1;
        regwrite_o = 1'b1;
      end
      MEMWR: begin
        iord_o     = 1'b1;
        memwrite_o = 1'b1;
      end
      RTYPEEX: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst_o   = 1'b1;
        regwrite_o = 1'b1;
      end
      BEQEX: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        branch_o  = 1'b1;
      end
      ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = ALUSRCB_IMM;
      end
      ADDIWB:  regwrite_o = 1'b1;
`ifdef MAINFSM_JUMP_EN
      JEX: begin
        pcwrite_o = 1'b1;
        pcsrc_o   = PCSRC_JUMP;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// mainfsm: main control FSM of the multi-cycle MIPS core.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset (forces FETCH, clears illegal_op)
//   ctrl  : mainfsm_if.master -- op in; enables, selects, aluop,
//           illegal_op and state out
// Holds the state register, next-state logic and the illegal_op register;
// the control word is decoded from state by mainfsm_outdec.
// Configuration macro: MAINFSM_JUMP_EN (when undefined, OP_J is illegal and
// JEX is never entered).
module mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mainfsm_if.master  ctrl
);

  statetype_t state_q, state_d;
  logic       illegal_q, illegal_d;

  // op only matters in DECODE and MEMADR; every other state is unconditional.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MAINFSM_JUMP_EN
          OP_J:         state_d = JEX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (ctrl.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Registered so the pulse lines up with the FETCH cycle that follows DECODE.
  assign illegal_d = (state_q == DECODE) && !op_supported(ctrl.op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign ctrl.state      = state_q;
  assign ctrl.illegal_op = illegal_q;

  mainfsm_outdec u_outdec (
    .state_i    (state_q),
    .irwrite_o  (ctrl.irwrite),
    .pcwrite_o  (ctrl.pcwrite),
    .branch_o   (ctrl.branch),
    .memwrite_o (ctrl.memwrite),
    .regwrite_o (ctrl.regwrite),
    .iord_o     (ctrl.iord),
    .memtoreg_o (ctrl.memtoreg),
    .regdst_o   (ctrl.regdst),
    .alusrca_o  (ctrl.alusrca),
    .alusrcb_o  (ctrl.alusrcb),
    .pcsrc_o    (ctrl.pcsrc),
    .aluop_o    (ctrl.aluop)
  );

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: scoreboard bench for mainfsm.
// Stimulus steps one clock at a time and pushes the expected state, control
// word and illegal_op for that cycle; a monitor pops and compares on each
// falling edge (or on demand right after an asynchronous reset).
// Configuration macro: MAINFSM_JUMP_EN selects the expected jump behaviour.
module tb_mainfsm;
  import mips_pkg::*;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] cw;
    logic        ill;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;
  int   pushCount = 0;
  event sampleNow;

  mainfsm_if bus();

  mainfsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  // Control word as listed in the state table, packed as
  // {irwrite,pcwrite,branch,memwrite,regwrite,iord,memtoreg,regdst,alusrca,
  //  alusrcb,pcsrc,aluop}.
  function automatic logic [14:0] expCtrl(input statetype_t s);
    logic irw, pcw, br, mw, rw, iord, mtr, rd, asa;
    logic [1:0] asb, pcs, aop;
    {irw, pcw, br, mw, rw, iord, mtr, rd, asa} = 9'b0;
    asb = 2'b00;
    pcs = 2'b00;
    aop = 2'b00;
    case (s)
      FETCH:   begin irw = 1; pcw = 1; asb = 2'b01; end
      DECODE:  asb = 2'b11;
      MEMADR:  begin asa = 1; asb = 2'b10; end
      MEMRD:   iord = 1;
      MEMWB:   begin mtr = 1; rw = 1; end
      MEMWR:   begin iord = 1; mw = 1; end
      RTYPEEX: begin asa = 1; aop = 2'b10; end
      RTYPEWB: begin rd = 1; rw = 1; end
      BEQEX:   begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      ADDIEX:  begin asa = 1; asb = 2'b10; end
      ADDIWB:  rw = 1;
      JEX:     begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {irw, pcw, br, mw, rw, iord, mtr, rd, asa, asb, pcs, aop};
  endfunction

  task automatic pushExp(input statetype_t s, input logic ill);
    exp_t e;
    e.st  = s;
    e.cw  = expCtrl(s);
    e.ill = ill;
    e.idx = pushCount;
    pushCount++;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [14:0] cw;
    cw = {bus.irwrite, bus.pcwrite, bus.branch, bus.memwrite, bus.regwrite,
          bus.iord, bus.memtoreg, bus.regdst, bus.alusrca,
          bus.alusrcb, bus.pcsrc, bus.aluop};
    checks++;
    if (bus.state !== e.st) begin
      errors++;
      $display("[TB] FAIL state #%0d: got %0d, expected %0d", e.idx, bus.state, e.st);
    end
    checks++;
    if (cw !== e.cw) begin
      errors++;
      $display("[TB] FAIL ctrl #%0d (state %0d): got %b, expected %b", e.idx, e.st, cw, e.cw);
    end
    checks++;
    if (bus.illegal_op !== e.ill) begin
      errors++;
      $display("[TB] FAIL illegal_op #%0d: got %b, expected %b", e.idx, bus.illegal_op, e.ill);
    end
  endtask

  // Monitor: compares whenever an expectation is waiting.
  initial begin
    forever begin
      @(negedge clk or sampleNow);
      if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    end
  end

  // One clock: op carries the instruction only where it is sampled and junk
  // elsewhere, so ignoring op outside DECODE/MEMADR is exercised too.
  task automatic stepCycle(input logic [5:0] opc, input statetype_t s, input logic ill);
    @(posedge clk);
    #1;
    bus.op = (s == DECODE || s == MEMADR) ? opc : ~opc;
    pushExp(s, ill);
  endtask

  // Expected states from DECODE up to the next FETCH; n is the CPI.
  task automatic applyStimulus(input logic [5:0] opc, input int n,
                               input statetype_t s0, input statetype_t s1,
                               input statetype_t s2, input statetype_t s3,
                               input statetype_t s4, input logic lastIll);
    statetype_t seq[5];
    seq = '{s0, s1, s2, s3, s4};
    for (int i = 0; i < n; i++)
      stepCycle(opc, seq[i], (i == n - 1) ? lastIll : 1'b0);
  endtask

  // Asserts reset away from any clock edge and checks the outputs at once,
  // then holds it over one edge before releasing.
  task automatic applyAsyncReset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    pushExp(FETCH, 1'b0);
    -> sampleNow;
    @(posedge clk);
    #1;
    pushExp(FETCH, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.op = OP_RTYPE;
    @(posedge clk);
    #1;
    pushExp(FETCH, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(OP_LW,   5, DECODE, MEMADR, MEMRD, MEMWB, FETCH, 1'b0);
    applyStimulus(OP_SW,   4, DECODE, MEMADR, MEMWR, FETCH, FETCH, 1'b0);
    applyStimulus(OP_RTYPE,4, DECODE, RTYPEEX, RTYPEWB, FETCH, FETCH, 1'b0);
    applyStimulus(OP_BEQ,  3, DECODE, BEQEX, FETCH, FETCH, FETCH, 1'b0);
    applyStimulus(OP_ADDI, 4, DECODE, ADDIEX, ADDIWB, FETCH, FETCH, 1'b0);
    applyStimulus(6'b111111, 2, DECODE, FETCH, FETCH, FETCH, FETCH, 1'b1);
    applyStimulus(OP_LW,   5, DECODE, MEMADR, MEMRD, MEMWB, FETCH, 1'b0);
`ifdef MAINFSM_JUMP_EN
    applyStimulus(OP_J,    3, DECODE, JEX, FETCH, FETCH, FETCH, 1'b0);
`else
    applyStimulus(OP_J,    2, DECODE, FETCH, FETCH, FETCH, FETCH, 1'b1);
`endif
    applyStimulus(6'b010101, 2, DECODE, FETCH, FETCH, FETCH, FETCH, 1'b1);
    applyStimulus(OP_BEQ,  3, DECODE, BEQEX, FETCH, FETCH, FETCH, 1'b0);

    // Reset in the middle of a load, then restart cleanly.
    applyStimulus(OP_LW,   3, DECODE, MEMADR, MEMRD, FETCH, FETCH, 1'b0);
    applyAsyncReset();
    applyStimulus(OP_SW,   4, DECODE, MEMADR, MEMWR, FETCH, FETCH, 1'b0);

    // Reset while the illegal_op pulse is high clears it immediately.
    applyStimulus(6'b111111, 2, DECODE, FETCH, FETCH, FETCH, FETCH, 1'b1);
    applyAsyncReset();
    applyStimulus(OP_RTYPE,4, DECODE, RTYPEEX, RTYPEWB, FETCH, FETCH, 1'b0);

    for (int i = 0; i < 5; i++) begin
      if (sbQ.size() == 0) break;
      @(negedge clk);
      #1;
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sbQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
